// File: rtl/shift_sequencer_if.sv
// Bundle between the control unit, the shift sequencer and the combinational shifter.
// The slave modport is the sequencer's view. The master modport is the control unit's and shifter's view.
interface shift_sequencer_if #(
  parameter int n     = 8,
  parameter int AMT_W = 4
);
  logic             start;
  logic             dir;
  logic [AMT_W-1:0] amount;
  logic [n-1:0]     din;
  logic [n-1:0]     sh_data;
  logic [2:0]       sh_ctrl;
  logic [n-1:0]     sh_result;
  logic [n-1:0]     result;
  logic             busy;
  logic             done;

  modport master (
    output start, dir, amount, din, sh_result,
    input  sh_data, sh_ctrl, result, busy, done
  );

  modport slave (
    input  start, dir, amount, din, sh_result,
    output sh_data, sh_ctrl, result, busy, done
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps an external n-bit shifter until the requested amount is consumed.
// Optional feature macro SHIFT_SEQ_QUAD_EN enables shift-by-2 steps while at least two positions remain.
module shift_sequencer #(
  parameter int n     = 8,
  parameter int AMT_W = 4
) (
  input logic              clk,
  input logic              reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] CTRL_SHL1 = 3'd0;
  localparam logic [2:0] CTRL_SHR1 = 3'd1;
  localparam logic [2:0] CTRL_PASS = 3'd2;
  localparam logic [2:0] CTRL_SHL2 = 3'd3;
  localparam logic [2:0] CTRL_SHR2 = 3'd4;

  state_t           state_reg;
  logic [n-1:0]     acc_reg;
  logic [AMT_W-1:0] rem_reg;
  logic             dir_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             quad_ok;
  logic [AMT_W-1:0] rem_next;
  logic [2:0]       ctrl_next;

  // Step selection depends only on registers, so sh_ctrl never sees sh_result.
  always_comb begin
`ifdef SHIFT_SEQ_QUAD_EN
    quad_ok = (rem_reg >= AMT_W'(2));
`else
    quad_ok = 1'b0;
`endif
    rem_next  = quad_ok ? rem_reg - AMT_W'(2) : rem_reg - AMT_W'(1);
    ctrl_next = CTRL_PASS;
    if (state_reg == SHIFT) begin
      if (quad_ok)
        ctrl_next = dir_reg ? CTRL_SHR2 : CTRL_SHL2;
      else
        ctrl_next = dir_reg ? CTRL_SHR1 : CTRL_SHL1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      rem_reg   <= '0;
      dir_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            acc_reg  <= bus.din;
            rem_reg  <= bus.amount;
            dir_reg  <= bus.dir;
            busy_reg <= 1'b1;
            if (bus.amount == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_reg <= bus.sh_result;
          rem_reg <= rem_next;
          if (rem_next == '0) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sh_data = acc_reg;
  assign bus.sh_ctrl = ctrl_next;
  assign bus.result  = acc_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized and directed bench for shift_sequencer.
// It checks the sequencer against a whole-operation reference model (result, step codes, latency).
module tb_shift_sequencer;
  localparam int N     = 8;
  localparam int AMT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  shift_sequencer_if #(.n(N), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.n(N), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Combinational shifter the sequencer drives.
  always_comb begin
    case (bus.sh_ctrl)
      3'd0:    bus.sh_result = bus.sh_data << 1;
      3'd1:    bus.sh_result = bus.sh_data >> 1;
      3'd2:    bus.sh_result = bus.sh_data;
      3'd3:    bus.sh_result = bus.sh_data << 2;
      3'd4:    bus.sh_result = bus.sh_data >> 2;
      default: bus.sh_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_result(input logic [N-1:0] d, input logic dr, input int a);
    int v;
    v = int'(d);
    if (a >= N) return '0;
    return dr ? N'(v >> a) : N'((v << a) & ((1 << N) - 1));
  endfunction

  function automatic int model_steps(input int a);
`ifdef SHIFT_SEQ_QUAD_EN
    return (a + 1) / 2;
`else
    return a;
`endif
  endfunction

  // One accepted request.  If inject is set, a conflicting start is pulsed while the request is busy.
  task automatic run_op(input logic [N-1:0] d, input logic dr, input int a, input bit inject);
    logic [N-1:0] exp_res;
    int           k;
    int           j;
    int           busy_cnt;
    logic [2:0]   seen[$];
    logic [2:0]   want[$];
    exp_res = model_result(d, dr, a);
    k       = model_steps(a);
`ifdef SHIFT_SEQ_QUAD_EN
    for (int i = 0; i < a / 2; i++) want.push_back(dr ? 3'd4 : 3'd3);
    if (a % 2 == 1) want.push_back(dr ? 3'd1 : 3'd0);
`else
    for (int i = 0; i < a; i++) want.push_back(dr ? 3'd1 : 3'd0);
`endif
    @(negedge clk);
    chk("idle_ctrl", 32'(bus.sh_ctrl), 32'd2);
    bus.start  = 1'b1;
    bus.din    = d;
    bus.dir    = dr;
    bus.amount = AMT_W'(a);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.din    = ~d;
    bus.amount = AMT_W'($urandom);
    busy_cnt   = 0;
    j          = 0;
    while (j <= 40 && !bus.done) begin
      if (bus.busy) busy_cnt++;
      chk("ctrl_range", 32'(bus.sh_ctrl <= 3'd4), 32'd1);
      seen.push_back(bus.sh_ctrl);
      if (inject && j == 1) begin
        bus.start = 1'b1;
        bus.din   = 8'h3C;
        bus.dir   = ~dr;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      j++;
    end
    bus.start = 1'b0;
    if (bus.busy) busy_cnt++;
    chk("latency", 32'(j), 32'(k));
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("done_ctrl", 32'(bus.sh_ctrl), 32'd2);
    chk("result", 32'(bus.result), 32'(exp_res));
    chk("busy_cycles", 32'(busy_cnt), 32'(k + 1));
    chk("ctrl_count", 32'(seen.size()), 32'(want.size()));
    for (int i = 0; i < seen.size() && i < want.size(); i++)
      chk("ctrl_seq", 32'(seen[i]), 32'(want[i]));
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("busy_fall", 32'(bus.busy), 32'd0);
    chk("result_held", 32'(bus.result), 32'(exp_res));
    $display("op din=%02h dir=%0d amt=%0d result=%02h expect=%02h steps=%0d", d, dr, a, bus.result, exp_res, j);
  endtask

  initial begin
    int done_cnt;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.dir    = 1'b0;
    bus.amount = '0;
    bus.din    = '0;
    #1;
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_data", 32'(bus.sh_data), 32'd0);
    chk("rst_ctrl", 32'(bus.sh_ctrl), 32'd2);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(8'h81, 1'b0, 3, 1'b0);
    run_op(8'hF0, 1'b1, 5, 1'b0);
    run_op(8'h5A, 1'b0, 0, 1'b0);
    run_op(8'hFF, 1'b0, 15, 1'b1);
    run_op(8'hFF, 1'b1, 8, 1'b0);
    run_op(8'hA5, 1'b1, 7, 1'b0);

    // Abort a long request mid-shift with an asynchronous reset.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.din    = 8'hFF;
    bus.dir    = 1'b0;
    bus.amount = 4'd15;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_abort_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_ctrl", 32'(bus.sh_ctrl), 32'd2);
    @(negedge clk);
    reset    = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(8'h81, 1'b0, 3, 1'b0);

    for (int t = 0; t < 40; t++)
      run_op(N'($urandom), 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
